alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 42 ++++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the two-requester ALU arbiter.
//   DATA_W / OP_W : operand and op-code widths
//   OP_*          : the eight ALU operation codes
//   state_t       : arbiter FSM state encoding
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: purely combinational 8-bit datapath.
//   a, b     : operands
//   op       : operation code (alu_pkg OP_*)
//   ctrl_in  : for shift/rotate ops, 1 selects b as the source, 0 selects a
//   result   : operation result
//   carry    : bit 8 of the 9-bit sum for add; 0 for every other op
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              ctrl_in,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] src;
    logic [DATA_W:0]   sum;

    assign src = ctrl_in ? b : a;
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ROL: result = {src[DATA_W-2:0], src[DATA_W-1]};
            OP_ROR: result = {src[0], src[DATA_W-1:1]};
            OP_SHL: result = {src[DATA_W-2:0], 1'b0};
            OP_SHR: result = {1'b0, src[DATA_W-1:1]};
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two valid/ready requesters onto a shared ALU and
// returns one registered response per accepted request (IDLE -> EXEC -> RESP).
//   clk, rst                  : clock, asynchronous active-high reset
//   reqN_valid/ready          : request handshake (ready is combinational in IDLE)
//   reqN_a/b/op/cin           : request payload
//   rsp_valid/ready           : response handshake
//   rsp_id/data/carry         : served requester and its result
//   busy                      : FSM not in IDLE
//   done_cnt0/1               : wrapping per-requester completion counters
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie
// instead of round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic              req1_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt0,
    output logic [CNT_W-1:0]  done_cnt1
);

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [OP_W-1:0]   cap_op;
    logic              cap_cin;
    logic              cap_id;
    logic              grant_c;
    logic              xfer_c;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    // Requester selection; only meaningful when at least one valid is high.
    always_comb begin
        grant_c = 1'b0;
        if (req1_valid && !req0_valid) begin
            grant_c = 1'b1;
        end else if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_c = 1'b0;
`else
            grant_c = ~last_grant;
`endif
        end
    end

    assign req0_ready = (state == ST_IDLE) && req0_valid && !grant_c;
    assign req1_ready = (state == ST_IDLE) && req1_valid && grant_c;
    assign xfer_c     = req0_ready || req1_ready;
    assign busy       = (state != ST_IDLE);

    alu u_alu (
        .a       (cap_a),
        .b       (cap_b),
        .op      (cap_op),
        .ctrl_in (cap_cin),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    // FSM, operand capture, response and completion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= '0;
            cap_cin    <= 1'b0;
            cap_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer_c) begin
                        cap_a      <= grant_c ? req1_a   : req0_a;
                        cap_b      <= grant_c ? req1_b   : req0_b;
                        cap_op     <= grant_c ? req1_op  : req0_op;
                        cap_cin    <= grant_c ? req1_cin : req0_cin;
                        cap_id     <= grant_c;
                        last_grant <= grant_c;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_carry <= alu_carry;
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                        if (rsp_id) begin
                            done_cnt1 <= done_cnt1 + CNT_W'(1);
                        end else begin
                            done_cnt0 <= done_cnt0 + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (CNT_W = 4).
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [7:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready, req1_cin;
    logic [7:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
    logic [7:0] rsp_data;
    logic [3:0] done_cnt0, done_cnt1;

    int n_pass;
    int n_total;
    logic [3:0] exp_cnt0, exp_cnt1;

    alu_arbiter #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .busy       (busy),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and collect its response; ok=0 on a timeout.
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic cin,
                         output logic [7:0] d, output logic c, output logic rid,
                         output logic ok);
        int k;
        ok = 1'b1;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_cin = cin;
        end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 20) ok = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!rsp_valid) ok = 1'b0;
        d   = rsp_data;
        c   = rsp_carry;
        rid = rsp_id;
        @(posedge clk); #1;
        if (ok) begin
            if (rid) exp_cnt1 = exp_cnt1 + 4'd1;
            else     exp_cnt0 = exp_cnt0 + 4'd1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_cin = 1'b0;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, busy, done_cnt0, done_cnt1} !== 20'h0) begin
            $display("FAIL reset_outputs: got v=%b id=%b d=%h c=%b busy=%b c0=%h c1=%h, want all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, busy, done_cnt0, done_cnt1);
        end else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            $display("FAIL idle_no_valid: got r0=%b r1=%b busy=%b, want 0 0 0",
                     req0_ready, req1_ready, busy);
        end else n_pass++;
    endtask

    task automatic test_add;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_op = 3'b000; req0_cin = 1'b0;
        #1;
        n_total++;
        if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            $display("FAIL add_grant: got r0=%b r1=%b busy=%b, want 1 0 0", req0_ready, req1_ready, busy);
        end else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_total++;
        if ({rsp_valid, busy, req0_ready} !== 3'b010) begin
            $display("FAIL add_exec: got v=%b busy=%b r0=%b, want 0 1 0", rsp_valid, busy, req0_ready);
        end else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            $display("FAIL add_resp: got v=%b id=%b d=%h c=%b, want 1 0 00 1",
                     rsp_valid, rsp_id, rsp_data, rsp_carry);
        end else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt0 = exp_cnt0 + 4'd1;
        n_total++;
        if ({rsp_valid, busy, done_cnt0, done_cnt1} !== {1'b0, 1'b0, exp_cnt0, exp_cnt1}) begin
            $display("FAIL add_done: got v=%b busy=%b c0=%h c1=%h, want 0 0 %h %h",
                     rsp_valid, busy, done_cnt0, done_cnt1, exp_cnt0, exp_cnt1);
        end else n_pass++;
    endtask

    typedef struct packed {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       cin;
        logic [7:0] d;
        logic       c;
    } vec_t;

    task automatic test_ops;
        vec_t vecs[11];
        logic [7:0] d;
        logic c, rid, ok;
        vecs[0]  = '{1'b1, 8'h10, 8'h20, 3'b001, 1'b0, 8'hF0, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 8'h81, 3'b100, 1'b1, 8'h03, 1'b0};
        vecs[2]  = '{1'b0, 8'hF0, 8'h3C, 3'b010, 1'b0, 8'h30, 1'b0};
        vecs[3]  = '{1'b0, 8'hF0, 8'h0F, 3'b011, 1'b0, 8'hFF, 1'b0};
        vecs[4]  = '{1'b1, 8'h01, 8'hFF, 3'b101, 1'b0, 8'h80, 1'b0};
        vecs[5]  = '{1'b0, 8'h81, 8'h00, 3'b110, 1'b0, 8'h02, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 8'h81, 3'b111, 1'b1, 8'h40, 1'b0};
        vecs[7]  = '{1'b0, 8'h80, 8'h7F, 3'b000, 1'b0, 8'hFF, 1'b0};
        vecs[8]  = '{1'b1, 8'h80, 8'h80, 3'b000, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 8'h05, 8'h06, 3'b001, 1'b0, 8'hFF, 1'b0};
        vecs[10] = '{1'b0, 8'h80, 8'h00, 3'b100, 1'b0, 8'h01, 1'b0};
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, d, c, rid, ok);
            n_total++;
            if (!ok || d !== vecs[i].d || c !== vecs[i].c || rid !== vecs[i].id) begin
                $display("FAIL op_vec%0d: got ok=%b id=%b d=%h c=%b, want ok=1 id=%b d=%h c=%b",
                         i, ok, rid, d, c, vecs[i].id, vecs[i].d, vecs[i].c);
            end else n_pass++;
        end
        n_total++;
        if (done_cnt0 !== exp_cnt0 || done_cnt1 !== exp_cnt1) begin
            $display("FAIL op_counts: got c0=%h c1=%h, want %h %h", done_cnt0, done_cnt1, exp_cnt0, exp_cnt1);
        end else n_pass++;
    endtask

    task automatic test_stall;
        logic bad;
        bad = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h40; req0_op = 3'b011; req0_cin = 1'b0;
        #1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01; req1_op = 3'b000; req1_cin = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy} !== {1'b1, 1'b0, 8'h52, 3'b001}
                || done_cnt0 !== exp_cnt0) begin
                bad = 1'b1;
                $display("FAIL stall_cycle%0d: got v=%b id=%b d=%h r0=%b r1=%b busy=%b c0=%h, want 1 0 52 0 0 1 %h",
                         i, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy, done_cnt0, exp_cnt0);
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (!bad) n_pass++;
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        exp_cnt0 = exp_cnt0 + 4'd1;
        @(posedge clk); #1;
        n_total++;
        if ({rsp_valid, busy} !== 2'b00 || done_cnt0 !== exp_cnt0 || done_cnt1 !== exp_cnt1) begin
            $display("FAIL stall_release: got v=%b busy=%b c0=%h c1=%h, want 0 0 %h %h",
                     rsp_valid, busy, done_cnt0, done_cnt1, exp_cnt0, exp_cnt1);
        end else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic exp_id [4];
        int got, k;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`else
        exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`endif
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'b000; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h3C; req1_op = 3'b010; req1_cin = 1'b0;
        got = 0;
        k = 0;
        while (got < 4 && k < 40) begin
            if (rsp_valid) begin
                n_total++;
                if (rsp_id !== exp_id[got] || rsp_data !== (exp_id[got] ? 8'h30 : 8'h03)) begin
                    $display("FAIL rr_grant%0d: got id=%b d=%h, want id=%b d=%h", got, rsp_id, rsp_data,
                             exp_id[got], exp_id[got] ? 8'h30 : 8'h03);
                end else n_pass++;
                if (exp_id[got]) exp_cnt1 = exp_cnt1 + 4'd1;
                else             exp_cnt0 = exp_cnt0 + 4'd1;
                got++;
                if (got == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            k++;
        end
        if (got < 4) begin
            n_total++;
            $display("FAIL rr_timeout: got %0d responses, want 4", got);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        n_total++;
        if (busy !== 1'b0 || done_cnt0 !== exp_cnt0 || done_cnt1 !== exp_cnt1) begin
            $display("FAIL rr_counts: got busy=%b c0=%h c1=%h, want 0 %h %h",
                     busy, done_cnt0, done_cnt1, exp_cnt0, exp_cnt1);
        end else n_pass++;
    endtask

    task automatic test_reset_exec;
        logic [7:0] d;
        logic c, rid, ok, seen;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 3'b000; req0_cin = 1'b0;
        #1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        n_total++;
        if ({rsp_valid, busy, rsp_data, rsp_id, rsp_carry, done_cnt0, done_cnt1} !== 19'h0) begin
            $display("FAIL rst_exec_immediate: got v=%b busy=%b d=%h id=%b c=%b c0=%h c1=%h, want all 0",
                     rsp_valid, busy, rsp_data, rsp_id, rsp_carry, done_cnt0, done_cnt1);
        end else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++;
        if (seen !== 1'b0) begin
            $display("FAIL rst_exec_no_resp: got activity=%b, want 0", seen);
        end else n_pass++;
        do_op(1'b0, 8'h10, 8'h22, 3'b000, 1'b0, d, c, rid, ok);
        n_total++;
        if (!ok || d !== 8'h32 || c !== 1'b0 || rid !== 1'b0 || done_cnt0 !== 4'd1 || done_cnt1 !== 4'd0) begin
            $display("FAIL rst_exec_recover: got ok=%b d=%h c=%b id=%b c0=%h c1=%h, want 1 32 0 0 1 0",
                     ok, d, c, rid, done_cnt0, done_cnt1);
        end else n_pass++;
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        logic c, rid, ok;
        int bad;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            do_op(1'b0, 8'h01, 8'h01, 3'b000, 1'b0, d, c, rid, ok);
            if (!ok) bad++;
        end
        n_total++;
        if (bad != 0 || done_cnt0 !== 4'hF) begin
            $display("FAIL wrap_preload: got timeouts=%0d c0=%h, want 0 f", bad, done_cnt0);
        end else n_pass++;
        do_op(1'b0, 8'h01, 8'h01, 3'b000, 1'b0, d, c, rid, ok);
        n_total++;
        if (!ok || done_cnt0 !== 4'h0 || done_cnt1 !== 4'h0) begin
            $display("FAIL wrap_to_zero: got ok=%b c0=%h c1=%h, want 1 0 0", ok, done_cnt0, done_cnt1);
        end else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_add();
        test_ops();
        test_stall();
        test_back_to_back();
        test_reset_exec();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
